// File: rtl/cltu_encoder.sv
// Serial CLTU generator: acquisition, start sequence, BCH(63,56) codeblocks and tail,
// one bit per BitEn strobe, fed from a byte-wide valid/ready source.
module cltu_encoder #(
    parameter int unsigned ACQ_BYTES  = 0,
    parameter logic [7:0]  FILL_BYTE  = 8'h55,
    parameter int unsigned MAX_BLOCKS = 32
) (
    input  logic        ClkI,
    input  logic        Rst,
    input  logic        BitEn,
    input  logic        TxStart,
    input  logic        Abort,
    input  logic [7:0]  DataIn,
    input  logic        DataValid,
    input  logic        DataLast,
    output logic        DataReady,
    output logic        SerOut,
    output logic        SerValid,
    output logic        Busy,
    output logic        Done,
    output logic        Underrun,
    output logic        OverLen,
    output logic [31:0] CltuCount
);

    localparam logic [15:0] START_SEQ = 16'hEB90;
    localparam logic [63:0] TAIL_SEQ  = 64'hC5C5_C5C5_C5C5_C579;
    localparam logic [6:0]  ACQ_LAST  = 7'(ACQ_BYTES * 8 - 1);
    localparam logic [15:0] MAX_BLK   = 16'(MAX_BLOCKS);

    typedef enum logic [2:0] {
        S_IDLE, S_ACQ, S_START, S_DATA, S_PAR, S_FILL, S_TAIL
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [15:0] blk_q, blk_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic        pad_q, pad_d;
    logic        ser_out_q, ser_out_d;
    logic        ser_valid_q, ser_valid_d;
    logic        done_q, done_d;
    logic        underrun_q, underrun_d;
    logic        overlen_q, overlen_d;
    logic [31:0] cltu_cnt_q, cltu_cnt_d;
    logic [6:0]  shreg_q, shreg_d;
    logic        data_ready;
    logic        data_bit;
    logic        fb;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        lfsr_d      = lfsr_q;
        pad_d       = pad_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        overlen_d   = 1'b0;
        cltu_cnt_d  = cltu_cnt_q;
        shreg_d     = shreg_q;
        data_bit    = 1'b0;
        fb          = 1'b0;
        data_ready  = (state_q == S_DATA) && BitEn && (cnt_q[2:0] == 3'd0) && !pad_q;

        if (Abort) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            blk_d       = '0;
            lfsr_d      = '0;
            pad_d       = 1'b0;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d  = '0;
                    blk_d  = '0;
                    lfsr_d = '0;
                    pad_d  = 1'b0;
                    if (BitEn) begin
                        ser_out_d   = 1'b0;
                        ser_valid_d = 1'b0;
                    end
                    // The accepting edge only arms the FSM; no bit leaves on it.
                    if (TxStart) state_d = (ACQ_BYTES > 0) ? S_ACQ : S_START;
                end
                S_ACQ: if (BitEn) begin
                    ser_out_d   = cnt_q[0];
                    ser_valid_d = 1'b1;
                    if (cnt_q == ACQ_LAST) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                S_START: if (BitEn) begin
                    ser_out_d   = START_SEQ[4'd15 - cnt_q[3:0]];
                    ser_valid_d = 1'b1;
                    if (cnt_q == 7'd15) begin
                        cnt_d   = '0;
                        lfsr_d  = '0;
                        state_d = S_DATA;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                S_DATA: if (BitEn) begin
                    if (cnt_q[2:0] == 3'd0) begin
                        // Byte slot: an empty source pads out the block rather than stalling.
                        if (pad_q || !DataValid) begin
                            data_bit   = FILL_BYTE[7];
                            shreg_d    = FILL_BYTE[6:0];
                            pad_d      = 1'b1;
                            underrun_d = !pad_q;
                        end else begin
                            data_bit = DataIn[7];
                            shreg_d  = DataIn[6:0];
                            pad_d    = DataLast;
                        end
                    end else begin
                        data_bit = shreg_q[6];
                        shreg_d  = {shreg_q[5:0], 1'b0};
                    end
                    ser_out_d   = data_bit;
                    ser_valid_d = 1'b1;
                    fb          = data_bit ^ lfsr_q[6];
                    lfsr_d      = {lfsr_q[5] ^ fb, lfsr_q[4:2], lfsr_q[1] ^ fb, lfsr_q[0], fb};
                    if (cnt_q == 7'd55) begin
                        cnt_d   = '0;
                        state_d = S_PAR;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                S_PAR: if (BitEn) begin
                    ser_out_d   = ~lfsr_q[6];
                    ser_valid_d = 1'b1;
                    lfsr_d      = {lfsr_q[5:0], 1'b0};
                    if (cnt_q == 7'd6) begin
                        cnt_d   = '0;
                        state_d = S_FILL;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                S_FILL: if (BitEn) begin
                    ser_out_d   = 1'b0;
                    ser_valid_d = 1'b1;
                    blk_d       = blk_q + 16'd1;
                    cnt_d       = '0;
                    if (pad_q) begin
                        state_d = S_TAIL;
                    end else if (blk_q + 16'd1 == MAX_BLK) begin
                        overlen_d = 1'b1;
                        state_d   = S_TAIL;
                    end else begin
                        lfsr_d  = '0;
                        state_d = S_DATA;
                    end
                end
                S_TAIL: if (BitEn) begin
                    ser_out_d   = TAIL_SEQ[6'd63 - cnt_q[5:0]];
                    ser_valid_d = 1'b1;
                    if (cnt_q == 7'd63) begin
                        cnt_d      = '0;
                        done_d     = 1'b1;
                        cltu_cnt_d = cltu_cnt_q + 32'd1;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ClkI or negedge Rst) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            blk_q       <= '0;
            lfsr_q      <= '0;
            pad_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            overlen_q   <= 1'b0;
            cltu_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_q       <= blk_d;
            lfsr_q      <= lfsr_d;
            pad_q       <= pad_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            overlen_q   <= overlen_d;
            cltu_cnt_q  <= cltu_cnt_d;
        end
    end

    // Byte shift register is pure datapath; every use is preceded by a load.
    always_ff @(posedge ClkI) begin
        shreg_q <= shreg_d;
    end

    assign DataReady = data_ready;
    assign SerOut    = ser_out_q;
    assign SerValid  = ser_valid_q;
    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign Underrun  = underrun_q;
    assign OverLen   = overlen_q;
    assign CltuCount = cltu_cnt_q;

endmodule

// File: tb/tb_cltu_encoder.sv
// Bench for cltu_encoder: random byte frames and strobe patterns checked against a
// polynomial-division reference of the CLTU bit stream, plus abort and reset cases.
module tb_cltu_encoder;

    localparam int         MAXB = 2;
    localparam logic [7:0] FILL = 8'h55;

    logic        ClkI = 1'b0;
    logic        Rst;
    logic        BitEn, TxStart, Abort, DataValid, DataLast;
    logic [7:0]  DataIn;
    logic        DataReady, SerOut, SerValid, Busy, Done, Underrun, OverLen;
    logic [31:0] CltuCount;

    cltu_encoder #(.ACQ_BYTES(0), .FILL_BYTE(FILL), .MAX_BLOCKS(MAXB)) dut (
        .ClkI(ClkI), .Rst(Rst), .BitEn(BitEn), .TxStart(TxStart), .Abort(Abort),
        .DataIn(DataIn), .DataValid(DataValid), .DataLast(DataLast),
        .DataReady(DataReady), .SerOut(SerOut), .SerValid(SerValid), .Busy(Busy),
        .Done(Done), .Underrun(Underrun), .OverLen(OverLen), .CltuCount(CltuCount)
    );

    always #5 ClkI = ~ClkI;

    typedef struct packed { logic [7:0] b; logic l; } ent_t;

    ent_t plan[$];
    ent_t src_q[$];
    bit   cap[$];
    bit   exp_bits[$];
    int   n_und, n_ovl, n_done, taken;
    int   exp_und, exp_ovl, exp_taken;
    int   exp_cltu = 0;
    int   checks = 0, passed = 0, failed = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(v[i]);
    endtask

    // Reference: builds the expected CLTU bit stream from the current plan.
    task automatic model();
        int         idx;
        int         blk;
        bit         ended;
        bit         pad;
        logic [7:0] blockb[7];
        bit         r[63];
        bit         cw[63];
        logic [7:0] gpoly;
        gpoly = 8'b1100_0101;
        idx = 0; blk = 0; ended = 0;
        exp_bits.delete(); exp_und = 0; exp_ovl = 0;
        push_bits(64'hEB90, 16);
        while (!ended) begin
            pad = 0;
            for (int s = 0; s < 7; s++) begin
                if (pad) blockb[s] = FILL;
                else if (idx < plan.size()) begin
                    blockb[s] = plan[idx].b;
                    if (plan[idx].l) pad = 1;
                    idx++;
                end else begin
                    blockb[s] = FILL;
                    pad = 1;
                    exp_und++;
                end
            end
            for (int s = 0; s < 7; s++)
                for (int k = 0; k < 8; k++) cw[s*8+k] = blockb[s][7-k];
            for (int i = 56; i < 63; i++) cw[i] = 0;
            r = cw;
            for (int i = 0; i < 56; i++)
                if (r[i]) for (int j = 0; j < 8; j++) r[i+j] ^= gpoly[7-j];
            for (int i = 0; i < 56; i++) exp_bits.push_back(cw[i]);
            for (int i = 56; i < 63; i++) exp_bits.push_back(!r[i]);
            exp_bits.push_back(1'b0);
            blk++;
            if (pad) ended = 1;
            else if (blk == MAXB) begin ended = 1; exp_ovl++; end
        end
        push_bits(64'hC5C5_C5C5_C5C5_C579, 64);
        exp_taken = idx;
    endtask

    // One clock: drive at the falling edge, observe at the next falling edge.
    task automatic tick(input bit ben);
        logic rdy;
        BitEn = ben;
        if (src_q.size() > 0) begin
            DataValid = 1'b1; DataIn = src_q[0].b; DataLast = src_q[0].l;
        end else begin
            DataValid = 1'b0; DataIn = 8'($urandom); DataLast = 1'($urandom);
        end
        #1;
        rdy = DataReady;
        @(posedge ClkI);
        if (rdy && DataValid) begin void'(src_q.pop_front()); taken++; end
        @(negedge ClkI);
        if (ben && SerValid === 1'b1) cap.push_back(SerOut);
        if (Underrun) n_und++;
        if (OverLen)  n_ovl++;
        if (Done)     n_done++;
    endtask

    task automatic clear_obs();
        cap.delete(); n_und = 0; n_ovl = 0; n_done = 0; taken = 0;
    endtask

    task automatic run_cltu(input string tag);
        int cyc;
        int mism;
        model();
        src_q = plan;
        clear_obs();
        TxStart = 1'b1;
        tick(1'($urandom_range(0, 1)));
        TxStart = 1'b0;
        chk({tag, ".busy"}, 64'(Busy), 64'd1);
        cyc = 0;
        while (n_done == 0 && cyc < 20000) begin
            tick($urandom_range(0, 2) != 0);
            cyc++;
        end
        repeat (3) tick(1'b1);
        exp_cltu++;
        mism = -1;
        for (int i = 0; i < cap.size() && i < exp_bits.size(); i++)
            if (cap[i] !== exp_bits[i] && mism < 0) mism = i;
        chk({tag, ".len"},      64'(cap.size()), 64'(exp_bits.size()));
        chk({tag, ".bits"},     64'(mism), 64'(-1));
        chk({tag, ".done"},     64'(n_done), 64'd1);
        chk({tag, ".underrun"}, 64'(n_und), 64'(exp_und));
        chk({tag, ".overlen"},  64'(n_ovl), 64'(exp_ovl));
        chk({tag, ".taken"},    64'(taken), 64'(exp_taken));
        chk({tag, ".count"},    64'(CltuCount), 64'(exp_cltu));
        chk({tag, ".idle"},     64'({Busy, SerValid}), 64'd0);
        src_q.delete();
    endtask

    task automatic make_plan(input int n, input bit last, input bit rnd, input logic [7:0] val);
        ent_t e;
        plan.delete();
        for (int i = 0; i < n; i++) begin
            e.b = rnd ? 8'($urandom) : val;
            e.l = last && (i == n - 1);
            plan.push_back(e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        Rst = 1'b0; BitEn = 1'b0; TxStart = 1'b0; Abort = 1'b0;
        DataValid = 1'b0; DataLast = 1'b0; DataIn = 8'h00;
        repeat (3) @(negedge ClkI);
        chk("rst.serout",   64'(SerOut), 64'd0);
        chk("rst.servalid", 64'(SerValid), 64'd0);
        chk("rst.busy",     64'(Busy), 64'd0);
        chk("rst.pulses",   64'({Done, Underrun, OverLen}), 64'd0);
        chk("rst.count",    64'(CltuCount), 64'd0);
        chk("rst.ready",    64'(DataReady), 64'd0);
        Rst = 1'b1;
        repeat (2) tick(1'b1);

        make_plan(7, 1, 0, 8'h00);  run_cltu("t1_zeros");
        make_plan(1, 1, 0, 8'hA5);  run_cltu("t2_a5");
        make_plan(2, 0, 1, 8'h00);  run_cltu("t4_underrun");
        make_plan(0, 0, 0, 8'h00);  run_cltu("empty");
        make_plan(20, 0, 1, 8'h00); run_cltu("t5_overlen");
        make_plan(14, 1, 1, 8'h00); run_cltu("last_at_max");
        for (int k = 0; k < 5; k++) begin
            make_plan($urandom_range(0, 16), 1'($urandom), 1, 8'h00);
            run_cltu($sformatf("rand%0d", k));
        end

        // Abort 40 bits into the first codeblock.
        make_plan(10, 0, 1, 8'h00);
        src_q = plan;
        clear_obs();
        TxStart = 1'b1; tick(1'b0); TxStart = 1'b0;
        cyc = 0;
        while (cap.size() < 56 && cyc < 2000) begin tick(1'($urandom)); cyc++; end
        chk("abort.reached", 64'(cap.size()), 64'd56);
        Abort = 1'b1; tick(1'b0); Abort = 1'b0;
        chk("abort.idle", 64'({Busy, SerValid}), 64'd0);
        src_q.delete();
        repeat (200) tick(1'b1);
        chk("abort.nodone", 64'(n_done), 64'd0);
        chk("abort.count",  64'(CltuCount), 64'(exp_cltu));
        TxStart = 1'b1; Abort = 1'b1; tick(1'b1); TxStart = 1'b0; Abort = 1'b0;
        chk("abort.beats_start", 64'(Busy), 64'd0);
        repeat (2) tick(1'b1);
        make_plan(9, 1, 1, 8'h00); run_cltu("after_abort");

        // Asynchronous reset in the middle of the start sequence.
        make_plan(5, 1, 1, 8'h00);
        src_q = plan;
        clear_obs();
        TxStart = 1'b1; tick(1'b1); TxStart = 1'b0;
        cyc = 0;
        while (cap.size() < 5 && cyc < 2000) begin tick(1'b1); cyc++; end
        chk("rstmid.reached", 64'(cap.size()), 64'd5);
        #2 Rst = 1'b0;
        #1;
        chk("rstmid.drop",  64'({SerOut, SerValid, Busy}), 64'd0);
        chk("rstmid.count", 64'(CltuCount), 64'd0);
        exp_cltu = 0;
        src_q.delete();
        @(negedge ClkI); @(negedge ClkI);
        Rst = 1'b1;
        repeat (200) tick(1'b1);
        chk("rstmid.nodone", 64'(n_done), 64'd0);
        chk("rstmid.idle",   64'({Busy, SerValid}), 64'd0);
        make_plan(3, 1, 1, 8'h00); run_cltu("after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
